// File: rtl/calc_pkg.sv
// Shared definitions for the calculation-core stages: control-word width and
// the occupancy-counter width helper.
package calc_pkg;

  localparam int CRL_W = 21;

  typedef logic [CRL_W-1:0] crl_t;

  // Bits needed to count 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data register of the elastic pipe. The data register only loads a
// valid source word, so bubbles never disturb the last word held.
module pipe_stage
  import calc_pkg::*;
#(
  parameter int DW = CRL_W
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_flush,
  input  logic          i_load,
  input  logic          i_src_valid,
  input  logic [DW-1:0] i_src_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      if (i_flush) begin
        o_valid <= 1'b0;
      end else if (i_load) begin
        o_valid <= i_src_valid;
      end
      if (i_load && i_src_valid) begin
        o_data <= i_src_data;
      end
    end
  end

endmodule

// File: rtl/window_pipe.sv
// Elastic DEPTH-stage valid/ready pipeline for window/census control words,
// with optional bubble collapsing, synchronous flush and an occupancy count.
module window_pipe
  import calc_pkg::*;
#(
  parameter int DW              = CRL_W,
  parameter int DEPTH           = 2,
  parameter int BUBBLE_COLLAPSE = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_flush,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [DW-1:0]                 i_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DW-1:0]                 o_data,
  output logic [count_width(DEPTH)-1:0] o_count
);

  localparam int CW = count_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DW-1:0]    d [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             any_empty;
  logic             in_xfer;
  logic             out_xfer;
  logic [CW-1:0]    count_q;

  // A stage may advance when any stage at or beyond it has a free slot, or the
  // consumer takes the output; in lockstep mode only the output stall matters.
  always_comb begin
    adv       = '0;
    any_empty = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (BUBBLE_COLLAPSE != 0) begin
        any_empty = any_empty | !v[k];
        adv[k]    = i_ready | any_empty;
      end else begin
        adv[k] = !v[DEPTH-1] | i_ready;
      end
    end
  end

  assign o_ready  = adv[0] & !i_flush;
  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = v[DEPTH-1] & i_ready;
  assign o_valid  = v[DEPTH-1];
  assign o_data   = d[DEPTH-1];
  assign o_count  = count_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          src_v;
    logic [DW-1:0] src_d;

    if (k == 0) begin : g_head
      assign src_v = in_xfer;
      assign src_d = i_data;
    end else begin : g_body
      assign src_v = v[k-1];
      assign src_d = d[k-1];
    end

    pipe_stage #(
      .DW(DW)
    ) u_stage (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_flush     (i_flush),
      .i_load      (adv[k]),
      .i_src_valid (src_v),
      .i_src_data  (src_d),
      .o_valid     (v[k]),
      .o_data      (d[k])
    );
  end

  // Occupancy tracks handshakes directly so it stays registered.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else if (i_flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
    end
  end

endmodule

// File: tb/tb_window_pipe.sv
// Scoreboard bench for window_pipe: three configurations share one random
// stimulus stream and are checked against a per-word position model.
module tb_window_pipe;

  localparam int NDUT = 3;
  localparam int DEP [NDUT] = '{4, 4, 1};
  localparam int BCM [NDUT] = '{1, 0, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        valid_in;
  logic        ready_in;
  logic [20:0] data_in;

  logic        o_ready0, o_ready1, o_ready2;
  logic        o_valid0, o_valid1, o_valid2;
  logic [20:0] o_data0, o_data1, o_data2;
  logic [2:0]  cnt0, cnt1;
  logic [0:0]  cnt2;

  logic [NDUT-1:0] ready_a;
  logic [NDUT-1:0] valid_a;
  logic [20:0]     data_a [NDUT];
  logic [31:0]     cnt_a [NDUT];

  int checks = 0;
  int failures = 0;

  int          pos_q [NDUT][$];
  logic [20:0] exp_q [NDUT][$];
  bit          armed = 1'b0;
  bit          just_reset = 1'b0;

  always #5 clk = ~clk;

  window_pipe #(.DW(21), .DEPTH(4), .BUBBLE_COLLAPSE(1)) u_bc1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid_in),
    .o_ready(o_ready0), .i_data(data_in), .o_valid(o_valid0), .i_ready(ready_in),
    .o_data(o_data0), .o_count(cnt0)
  );

  window_pipe #(.DW(21), .DEPTH(4), .BUBBLE_COLLAPSE(0)) u_bc0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid_in),
    .o_ready(o_ready1), .i_data(data_in), .o_valid(o_valid1), .i_ready(ready_in),
    .o_data(o_data1), .o_count(cnt1)
  );

  window_pipe #(.DW(21), .DEPTH(1), .BUBBLE_COLLAPSE(1)) u_d1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid_in),
    .o_ready(o_ready2), .i_data(data_in), .o_valid(o_valid2), .i_ready(ready_in),
    .o_data(o_data2), .o_count(cnt2)
  );

  always_comb begin
    ready_a   = {o_ready2, o_ready1, o_ready0};
    valid_a   = {o_valid2, o_valid1, o_valid0};
    data_a[0] = o_data0;
    data_a[1] = o_data1;
    data_a[2] = o_data2;
    cnt_a[0]  = 32'(cnt0);
    cnt_a[1]  = 32'(cnt1);
    cnt_a[2]  = 32'(cnt2);
  end

  task automatic check_output(input string name, input int dut,
                              input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s dut%0d actual=0x%0h expected=0x%0h t=%0t",
               name, dut, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [20:0] dat, input logic r,
                                input logic f, input logic rn);
    valid_in = v;
    data_in  = dat;
    ready_in = r;
    flush    = f;
    rst_n    = rn;
    @(posedge clk);
    #1;
  endtask

  // Reference model: each in-flight word has a slot position; it moves one slot
  // forward per cycle unless blocked by the word ahead (or, in lockstep mode,
  // by a stalled output). A word is visible at the output in slot DEPTH-1.
  int  sz, lim, newp;
  logic ev, er;
  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      sz = pos_q[d].size();
      ev = (sz > 0) && (pos_q[d][0] == DEP[d] - 1);
      if (BCM[d] != 0) er = ((sz < DEP[d]) || ready_in) && !flush;
      else             er = (!ev || ready_in) && !flush;
      if (armed) begin
        check_output("valid", d, 32'(valid_a[d]), 32'(ev));
        check_output("count", d, cnt_a[d], 32'(sz));
        check_output("ready", d, 32'(ready_a[d]), 32'(er));
        if (just_reset) check_output("data_after_reset", d, 32'(data_a[d]), 32'd0);
      end
      if (!rst_n || flush) begin
        pos_q[d].delete();
      end else begin
        if (ev && ready_in) void'(pos_q[d].pop_front());
        if (BCM[d] != 0) begin
          lim = DEP[d] - 1;
          for (int i = 0; i < pos_q[d].size(); i++) begin
            newp = pos_q[d][i] + 1;
            if (newp > lim) newp = lim;
            pos_q[d][i] = newp;
            lim = newp - 1;
          end
        end else if (!ev || ready_in) begin
          for (int i = 0; i < pos_q[d].size(); i++) pos_q[d][i] = pos_q[d][i] + 1;
        end
        if (valid_in && er) begin
          pos_q[d].push_back(0);
          exp_q[d].push_back(data_in);
        end
      end
    end
    if (!rst_n) armed = 1'b1;
    just_reset = !rst_n;
  end

  // Monitor: whatever the DUT presents must be the oldest outstanding word.
  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < NDUT; d++) begin
        if (!rst_n) begin
          exp_q[d].delete();
        end else begin
          if (valid_a[d]) begin
            check_output("sb_nonempty", d, 32'(exp_q[d].size() != 0), 32'd1);
            if (exp_q[d].size() != 0) begin
              check_output("data", d, 32'(data_a[d]), 32'(exp_q[d][0]));
              if (ready_in) void'(exp_q[d].pop_front());
            end
          end
          if (flush) exp_q[d].delete();
        end
      end
    end
  end

  initial begin
    apply_stimulus(1'b0, 21'd0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 21'd0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 21'(i), 1'b1, 1'b0, 1'b1);
    for (int i = 10; i < 16; i++) apply_stimulus(1'b1, 21'(i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 21'd0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) apply_stimulus((i % 2) == 0, 21'(100 + i), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 21'(200 + i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b0, 21'd0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 21'(300 + i), 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 21'd400, 1'b1, 1'b1, 1'b1);
    apply_stimulus(1'b0, 21'd0, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 21'd500, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 21'd0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 21'(600 + i), 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, 21'd700, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 21'(800 + i), 1'b1, 1'b0, 1'b1);
    valid_in = 1'b1;
    data_in  = 21'd900;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 21'd0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++)
      apply_stimulus(1'b1, (i % 2) == 0 ? 21'h1FFFFF : 21'h000001, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 21'd0, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++)
      apply_stimulus($urandom_range(0, 9) < 7, 21'($urandom), $urandom_range(0, 9) < 6,
                     $urandom_range(0, 29) == 0, $urandom_range(0, 99) != 0);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 21'd0, 1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
